// File: rtl/fir_lms_seq_pkg.sv
// Shared types, default sizing and saturation helpers for the sequential LMS FIR.
// The helpers work on a 64-bit carrier so one definition serves every width.
package fir_lms_pkg;

   localparam int W1_DEF       = 8;
   localparam int W2_DEF       = 2 * W1_DEF;
   localparam int L_DEF        = 2;
   localparam int MU_SHIFT_DEF = 1;
   localparam int AW_DEF       = $clog2(L_DEF);

   typedef enum logic [2:0] {IDLE, FILTER, ERROR, UPDATE, OUT} state_e;
   typedef enum logic {MAC_ACC, MAC_UPD} mac_mode_e;

   // Worst case L products of W1xW1 cannot overflow this width.
   function automatic int acc_width(input int w1, input int aw);
      return 2 * w1 + aw;
   endfunction

   function automatic logic signed [63:0] sat_n(input logic signed [63:0] v,
                                                input int unsigned n);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (n - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (n - 1));
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

   function automatic logic signed [63:0] sat_W1(input logic signed [63:0] v,
                                                 input int unsigned w1);
      return sat_n(v, w1);
   endfunction

   function automatic logic signed [63:0] sat_W2(input logic signed [63:0] v,
                                                 input int unsigned w2);
      return sat_n(v, w2);
   endfunction

endpackage

// File: rtl/fir_lms_seq_if.sv
// Sample/result/readback bundle for fir_lms_seq; the source side is the master.
interface fir_lms_seq_if #(
   parameter int W1 = fir_lms_pkg::W1_DEF,
   parameter int W2 = fir_lms_pkg::W2_DEF,
   parameter int AW = fir_lms_pkg::AW_DEF
);
   logic                 in_valid;
   logic                 in_ready;
   logic signed [W1-1:0] x_in;
   logic signed [W1-1:0] d_in;
   logic                 adapt_en;
   logic                 coef_clr;
   logic [AW-1:0]        coef_addr;
   logic signed [W1-1:0] coef_out;
   logic                 out_valid;
   logic signed [W2-1:0] y_out;
   logic signed [W2-1:0] e_out;
   logic                 busy;

   modport master (
      output in_valid, x_in, d_in, adapt_en, coef_clr, coef_addr,
      input  in_ready, coef_out, out_valid, y_out, e_out, busy
   );

   modport slave (
      input  in_valid, x_in, d_in, adapt_en, coef_clr, coef_addr,
      output in_ready, coef_out, out_valid, y_out, e_out, busy
   );
endinterface

// File: rtl/fir_lms_seq_mac.sv
// Single shared W1xW1 multiplier: accumulates x*f while filtering, and forms the
// saturated coefficient update f + (emu*x >>> W1) while adapting.
module lms_mac_unit
   import fir_lms_pkg::*;
#(
   parameter int W1    = W1_DEF,
   parameter int ACC_W = 2 * W1_DEF + 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  mac_mode_e               mode,
   input  logic                    en,
   input  logic                    clr,
   input  logic signed [W1-1:0]    xk,
   input  logic signed [W1-1:0]    fk,
   input  logic signed [W1-1:0]    emu,
   output logic signed [ACC_W-1:0] acc,
   output logic signed [W1-1:0]    f_new
);
   logic signed [W1-1:0]   mb;
   logic signed [2*W1-1:0] prod;

   assign mb    = (mode == MAC_UPD) ? emu : fk;
   assign prod  = (2*W1)'(xk) * (2*W1)'(mb);
   assign f_new = W1'(sat_W1(64'(fk) + 64'(prod >>> W1), W1));

   always_ff @(posedge clk) begin
      if (!reset)   acc <= '0;
      else if (clr) acc <= '0;
      else if (en)  acc <= acc + ACC_W'(prod);
   end
endmodule

// File: rtl/fir_lms_seq.sv
// L-tap LMS adaptive FIR sharing one multiplier across FILTER and UPDATE phases.
// Coefficient update is a-priori: it reuses the x line and f seen during FILTER.
module fir_lms_seq
   import fir_lms_pkg::*;
#(
   parameter int W1       = W1_DEF,
   parameter int W2       = W2_DEF,
   parameter int L        = L_DEF,
   parameter int MU_SHIFT = MU_SHIFT_DEF,
   parameter int AW       = $clog2(L)
) (
   input  logic         clk,
   input  logic         reset,
   fir_lms_seq_if.slave bus
);
   localparam int            ACC_W  = acc_width(W1, AW);
   localparam logic [AW-1:0] K_LAST = AW'(L - 1);

   state_e                  state_q, state_d;
   logic [AW-1:0]           k_q, k_d;
   logic [L-1:0][W1-1:0]    x_q, f_q;
   logic signed [W1-1:0]    d_q, emu_q, emu_c, f_new;
   logic signed [W2-1:0]    ys_q, e_q, ys_c, e_c;
   logic signed [ACC_W-1:0] acc;
   logic                    adapt_q, accept, clr_f, mac_en;
   mac_mode_e               mac_mode;

   assign bus.in_ready = (state_q == IDLE) && !bus.coef_clr && reset;
   assign bus.busy     = (state_q != IDLE);

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      accept   = 1'b0;
      clr_f    = 1'b0;
      mac_en   = 1'b0;
      mac_mode = MAC_ACC;
      case (state_q)
         IDLE: begin
            clr_f  = bus.coef_clr;
            accept = bus.in_valid && bus.in_ready;
            if (accept) begin
               state_d = FILTER;
               k_d     = '0;
            end
         end
         FILTER: begin
            mac_en = 1'b1;
            k_d    = (k_q == K_LAST) ? '0 : k_q + AW'(1);
            if (k_q == K_LAST) state_d = ERROR;
         end
         ERROR:  state_d = adapt_q ? UPDATE : OUT;
         UPDATE: begin
            mac_mode = MAC_UPD;
            k_d      = (k_q == K_LAST) ? '0 : k_q + AW'(1);
            if (k_q == K_LAST) state_d = OUT;
         end
         OUT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Error-phase arithmetic; the 64-bit carrier covers the W2+1 bit difference.
   always_comb begin
      ys_c  = W2'(sat_W2(64'(acc >>> (W1 - 1)), W2));
      e_c   = W2'(sat_W2(64'(d_q) - 64'(ys_c), W2));
      emu_c = W1'(sat_W1(64'(e_c >>> MU_SHIFT), W1));
   end

   lms_mac_unit #(.W1(W1), .ACC_W(ACC_W)) u_mac (
      .clk   (clk),
      .reset (reset),
      .mode  (mac_mode),
      .en    (mac_en),
      .clr   (accept),
      .xk    (x_q[k_q]),
      .fk    (f_q[k_q]),
      .emu   (emu_q),
      .acc   (acc),
      .f_new (f_new)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= IDLE;
         k_q           <= '0;
         x_q           <= '0;
         f_q           <= '0;
         d_q           <= '0;
         adapt_q       <= 1'b0;
         ys_q          <= '0;
         e_q           <= '0;
         emu_q         <= '0;
         bus.coef_out  <= '0;
         bus.out_valid <= 1'b0;
         bus.y_out     <= '0;
         bus.e_out     <= '0;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         bus.out_valid <= 1'b0;
         bus.coef_out  <= (int'(bus.coef_addr) < L) ? f_q[bus.coef_addr] : '0;
         if (accept) begin
            x_q     <= {x_q[L-2:0], bus.x_in};
            d_q     <= bus.d_in;
            adapt_q <= bus.adapt_en;
         end
         if (clr_f) f_q <= '0;
         if (state_q == ERROR) begin
            ys_q  <= ys_c;
            e_q   <= e_c;
            emu_q <= emu_c;
         end
         if (state_q == UPDATE) f_q[k_q] <= f_new;
         if (state_q == OUT) begin
            bus.y_out     <= ys_q;
            bus.e_out     <= e_q;
            bus.out_valid <= 1'b1;
         end
      end
   end
endmodule

// File: doc/fir_lms_seq.md
Name: fir_lms_seq

Overview:
- Parametrised successor to the two-tap LMS adaptive FIR: L taps, configurable step size (power-of-two shift), saturating arithmetic throughout.
- Uses one time-multiplexed multiplier, driven by an FSM, instead of 2L parallel multipliers.
- Sample-rate interface with valid/ready handshake; per-sample adapt enable; coefficient clear; addressed coefficient readback.
- Sits between the sample source and the error/monitor logic in adaptive equaliser and noise-canceller datapaths.

Parameters:
- W1, 8: data/coefficient width; signed fractional format with W1-1 fraction bits.
- W2, 16: output/error width; must equal 2*W1.
- L, 2: filter length; L >= 2.
- MU_SHIFT, 1: step size mu = 2^-(MU_SHIFT+1), applied as an arithmetic right shift of the error.
- AW, clog2(L): coefficient address width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  x_in/d_in valid.
- in_ready  out  1  block can accept a sample.
- x_in  in  W1 signed  filter input sample.
- d_in  in  W1 signed  desired/reference sample.
- adapt_en  in  1  sampled at acceptance; 0 freezes coefficients for that sample.
- coef_clr  in  1  clears all coefficients; honoured only in IDLE.
- coef_addr  in  AW  coefficient readback index.
- coef_out  out  W1 signed  f[coef_addr], registered, 1-cycle latency.
- out_valid  out  1  one-cycle pulse; y_out/e_out updated this cycle.
- y_out  out  W2 signed  filter output, scaled (acc >>> (W1-1)).
- e_out  out  W2 signed  error d - y.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (reset==0 at a clk edge): x[0..L-1], f[0..L-1], d, acc, y_out, e_out, coef_out all 0; out_valid=0; state IDLE. in_ready=0 while reset is low. Reset mid-operation aborts the sample; no out_valid.
- in_ready = (state==IDLE) && !coef_clr && reset.
- Accept when in_valid && in_ready:
  - x[0]<=x_in; x[k]<=x[k-1]; d<=d_in.
  - adapt_en latched; acc cleared.
  - Go to FILTER.
- FILTER (L cycles, k=0..L-1): acc += x[k]*f[k]. acc width is 2*W1+AW, so no overflow is possible.
- ERROR (1 cycle):
  - ys = sat_W2(acc >>> (W1-1)).
  - e = sat_W2(d - ys), computed at W2+1 bits.
  - emu = sat_W1(e >>> MU_SHIFT).
  - Latch ys and e.
  - Next state is UPDATE if adapt_en was latched as 1, else OUT.
- UPDATE (L cycles, k=0..L-1): f[k] <= sat_W1(f[k] + ((emu*x[k]) >>> W1)).
  - Right shifts are arithmetic.
  - Update is a-priori: uses the same x line and the pre-update f used in FILTER.
- OUT (1 cycle): y_out<=ys, e_out<=e, out_valid=1; then IDLE.
- Latency, accept to out_valid: 2L+2 cycles adapting, L+2 cycles frozen. Throughput: one sample per 2L+3 cycles (L+3 frozen).
- y_out/e_out hold their value between out_valid pulses.
- coef_clr in IDLE: all f<=0 next cycle; a simultaneous in_valid is not accepted. coef_clr outside IDLE is ignored.
- Saturation: clamp to [-2^(N-1), 2^(N-1)-1]; never wrap.
- coef_addr >= L: coef_out=0.
- in_valid outside IDLE is ignored; the source must hold data until in_ready.

Decomposition:
- Package fir_lms_pkg holds:
  - state enum IDLE/FILTER/ERROR/UPDATE/OUT;
  - sat functions sat_W1 and sat_W2;
  - AW/accumulator-width constants.
- One sub-module, lms_mac_unit: shared signed W1xW1 multiplier with a mode select (accumulate for FILTER, saturating coefficient update for UPDATE).

Test Plan (W1=8, L=2, MU_SHIFT=1):
- Reset, then x_in=64, d_in=64, adapt_en=1 -> out_valid 6 cycles after accept; y_out=0, e_out=64; f[0]=8, f[1]=0 via coef readback.
- Second sample x_in=64, d_in=64 -> y_out=4, e_out=60; f=[15,7].
- Same two samples with adapt_en=0 -> out_valid 4 cycles after accept; e_out=64 both times; f stays [0,0].
- Sustained x_in=127, d_in=127 for 200 samples -> no f[k] ever above 127; e_out monotone non-increasing toward 0; no wrap.
- coef_clr asserted together with in_valid in IDLE -> in_ready=0, sample not taken; f=[0,0] next cycle; sample accepted the following cycle.
- reset low during UPDATE -> no out_valid; all outputs 0; in_ready=1 one cycle after reset returns high.
